// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - byte-wide instruction fetch with little-endian assembly and program-load write path
module instr_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i,
    input  logic [7:0]        instr8bit_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wd_o,
    output logic              ready_o,
    output logic [31:0]       instr_o,
    output logic              valid_o
);

    typedef enum logic [1:0] {IDLE, LOAD, FETCH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [2:0]        iss_cnt;
    logic [1:0]        cap_cnt;
    logic [MEM_LAT:0]  iss_pipe;
    logic [23:0]       asm_q;
    logic              issue_now;
    logic              capture;

    // Each issued address produces a byte MEM_LAT+1 edges later; the pipe tracks that.
    assign capture   = iss_pipe[MEM_LAT];
    assign issue_now = ((state == IDLE) && !load_i && req_i) ||
                       ((state == FETCH) && !flush_i && (iss_cnt < 3'd4));
    assign ready_o   = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_i)     state_nxt = LOAD;
                else if (req_i) state_nxt = FETCH;
            end
            LOAD:  state_nxt = IDLE;
            FETCH: begin
                if (flush_i)                         state_nxt = IDLE;
                else if (capture && cap_cnt == 2'd3) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_o <= '0;
            mem_we_o   <= 1'b0;
            mem_wd_o   <= '0;
            instr_o    <= '0;
            valid_o    <= 1'b0;
            base       <= '0;
            iss_cnt    <= '0;
            cap_cnt    <= '0;
            iss_pipe   <= '0;
            asm_q      <= '0;
        end else begin
            valid_o  <= 1'b0;
            mem_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_i) begin
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= load_addr_i;
                        mem_wd_o   <= load_data_i;
                    end else if (req_i) begin
                        base       <= pc_i;
                        mem_addr_o <= pc_i;
                        iss_cnt    <= 3'd1;
                        cap_cnt    <= 2'd0;
                    end
                end
                FETCH: begin
                    if (!flush_i) begin
                        if (iss_cnt < 3'd4) begin
                            mem_addr_o <= base + ADDR_W'(iss_cnt);
                            iss_cnt    <= iss_cnt + 3'd1;
                        end
                        if (capture) begin
                            cap_cnt <= cap_cnt + 2'd1;
                            case (cap_cnt)
                                2'd0: asm_q[7:0]   <= instr8bit_i;
                                2'd1: asm_q[15:8]  <= instr8bit_i;
                                2'd2: asm_q[23:16] <= instr8bit_i;
                                default: begin
                                    instr_o <= {instr8bit_i, asm_q};
                                    valid_o <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
            // Leaving FETCH drops any bytes still in flight.
            if (state_nxt == FETCH) begin
                iss_pipe <= {iss_pipe[MEM_LAT-1:0], issue_now};
            end else begin
                iss_pipe <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a byte-wide registered memory
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        load_i = 1'b0;
    logic [31:0] load_addr_i = '0;
    logic [31:0] load_data_i = '0;
    logic [7:0]  rdata = '0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wd_o;
    logic        ready_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int k0;

    typedef struct {
        logic [31:0] instr;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem [0:255];

    instr_fetch_unit #(.ADDR_W(32), .MEM_LAT(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .load_i      (load_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i),
        .instr8bit_i (rdata),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wd_o    (mem_wd_o),
        .ready_o     (ready_o),
        .instr_o     (instr_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int k = 0; k < 4; k++) begin
                mem[8'(mem_addr_o[7:0] + 8'(k))] = mem_wd_o[8*k +: 8];
            end
            wr_cnt++;
        end
        rdata <= mem[mem_addr_o[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] instr, input int at);
        exp_t e;
        e.instr = instr;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual instr=%h expected no valid (cycle %0d)", instr_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("instr_value", instr_o, e.instr);
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[4] = 8'h08; mem[5] = 8'h00; mem[6] = 8'h03; mem[7] = 8'h20;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;

        // reset
        wait_neg(2);
        rst_i = 1'b0;
        chk("rst_addr",  mem_addr_o, 32'h0);
        chk("rst_we",    32'(mem_we_o), 32'h0);
        chk("rst_wd",    mem_wd_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h1);

        // load then fetch
        load_i = 1'b1; load_addr_i = 32'h0; load_data_i = 32'h00852020;
        wait_neg(1);
        load_i = 1'b0;
        chk("load_we",    32'(mem_we_o), 32'h1);
        chk("load_addr",  mem_addr_o, 32'h0);
        chk("load_wd",    mem_wd_o, 32'h00852020);
        chk("load_ready", 32'(ready_o), 32'h0);
        wait_neg(1);
        chk("load_we_drop", 32'(mem_we_o), 32'h0);
        chk("load_ready_back", 32'(ready_o), 32'h1);
        chk("load_wr_cnt", 32'(wr_cnt), 32'h1);

        // fetch pc=0, then back-to-back pc=4 with req_i held
        k0 = cyc;
        req_i = 1'b1; pc_i = 32'h0;
        push(32'h00852020, k0 + 6);
        push(32'h20030008, k0 + 12);
        for (int i = 0; i < 4; i++) begin
            wait_neg(1);
            chk("addr_seq0", mem_addr_o, 32'(i));
            chk("fetch_we0", 32'(mem_we_o), 32'h0);
            if (i == 0) pc_i = 32'h4;
        end
        while (cyc < k0 + 7) wait_neg(1);
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("addr_seq4", mem_addr_o, 32'(4 + i));
            wait_neg(1);
        end
        while (cyc < k0 + 14) wait_neg(1);
        chk("b2b_drained", 32'(exp_q.size()), 32'h0);
        chk("fetch_no_writes", 32'(wr_cnt), 32'h1);

        // flush during third FETCH cycle
        req_i = 1'b1; pc_i = 32'h0;
        wait_neg(1);
        req_i = 1'b0;
        wait_neg(2);
        flush_i = 1'b1;
        wait_neg(1);
        flush_i = 1'b0;
        chk("flush_ready", 32'(ready_o), 32'h1);
        wait_neg(8);
        chk("flush_instr_hold", instr_o, 32'h20030008);

        // flush on the completion edge
        req_i = 1'b1; pc_i = 32'h0;
        wait_neg(1);
        req_i = 1'b0;
        wait_neg(4);
        flush_i = 1'b1;
        wait_neg(1);
        flush_i = 1'b0;
        chk("cflush_ready", 32'(ready_o), 32'h1);
        chk("cflush_valid", 32'(valid_o), 32'h0);
        chk("cflush_instr_hold", instr_o, 32'h20030008);
        wait_neg(6);

        // a clean fetch after the flushes must assemble fresh bytes
        req_i = 1'b1; pc_i = 32'h0;
        push(32'h00852020, cyc + 6);
        wait_neg(1);
        req_i = 1'b0;
        wait_neg(7);
        chk("post_flush_drained", 32'(exp_q.size()), 32'h0);

        // reset mid-fetch
        req_i = 1'b1; pc_i = 32'h4;
        wait_neg(1);
        req_i = 1'b0;
        wait_neg(1);
        rst_i = 1'b1;
        wait_neg(1);
        rst_i = 1'b0;
        chk("midrst_ready", 32'(ready_o), 32'h1);
        chk("midrst_addr",  mem_addr_o, 32'h0);
        chk("midrst_instr", instr_o, 32'h0);
        wait_neg(8);
        chk("midrst_addr_quiet", mem_addr_o, 32'h0);

        // address wrap
        req_i = 1'b1; pc_i = 32'hFFFF_FFFE;
        push(32'h20202211, cyc + 6);
        for (int i = 0; i < 4; i++) begin
            wait_neg(1);
            req_i = 1'b0;
            chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFE + 32'(i));
        end
        wait_neg(4);
        chk("wrap_drained", 32'(exp_q.size()), 32'h0);

        // load beats req in IDLE
        load_i = 1'b1; load_addr_i = 32'h40; load_data_i = 32'hA5A5_5A5A;
        req_i = 1'b1; pc_i = 32'h4;
        wait_neg(1);
        load_i = 1'b0; req_i = 1'b0;
        chk("prio_we",    32'(mem_we_o), 32'h1);
        chk("prio_addr",  mem_addr_o, 32'h40);
        chk("prio_ready", 32'(ready_o), 32'h0);
        wait_neg(1);
        chk("prio_ready_back", 32'(ready_o), 32'h1);
        chk("prio_wr_cnt", 32'(wr_cnt), 32'h2);
        chk("prio_mem_byte3", 32'(mem[8'h43]), 32'hA5);
        wait_neg(8);
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
